button_debounce: RTL
====================

Name: button_debounce

Overview:
- Input conditioner for the eight panel pushbuttons: morse_left, morse_right, morse_tx, keypad_TL, keypad_TR, keypad_LL, keypad_LR and button_bigButton.
- Sits directly upstream of the button memory-mapped read window. Raw pins pass through a 2-flop synchroniser and a per-channel debounce counter.
- Produces clean levels, one-cycle press pulses and sticky press flags. Software clears the flags through a write-strobe mask.
- Bit order of every vector: [7]=morse_left, [6]=morse_right, [5]=morse_tx, [4]=keypad_TL, [3]=keypad_TR, [2]=keypad_LL, [1]=keypad_LR, [0]=button_bigButton.

Parameters:
NUM_BTN, 8, number of button channels
DEBOUNCE_CYCLES, 500000, cycles a synchronised level must hold before it is accepted (10 ms at 50 MHz); minimum 1
CNT_WIDTH, 19, counter width; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (pull-up wiring); 0 = pin reads 1 when pressed

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_raw  input  NUM_BTN  raw asynchronous button pins
clr_en  input  1  clear strobe (from a bus write decode)
clr_mask  input  NUM_BTN  per-channel clear select; acted on only when clr_en=1
btn_state  output  NUM_BTN  debounced level, 1 = pressed
btn_press  output  NUM_BTN  one-cycle pulse on debounced press
btn_latched  output  NUM_BTN  sticky press flags
any_press  output  1  OR-reduction of btn_latched (registered)

Behaviour:
Interface and reset:
- One clock: clk. Reset is asynchronous and active-low: rst_n.
- While rst_n=0: both synchroniser stages hold the released pin level (ACTIVE_LOW ? 1 : 0); counters = 0; btn_state, btn_press, btn_latched and any_press = 0.
- Deassertion takes effect on the next clk edge. No output glitches on deassertion.

Synchroniser:
- Two flops per channel: s1 <= btn_raw, s2 <= s1.
- Pressed level p = ACTIVE_LOW ? ~s2 : s2.

Debounce, per channel, independent:
- If p == btn_state: counter <= 0.
- Else if counter == DEBOUNCE_CYCLES-1: btn_state <= p, counter <= 0.
- Else: counter <= counter+1.
- Any cycle where p returns to btn_state restarts the count. Glitches shorter than DEBOUNCE_CYCLES cycles are rejected entirely.
- Latency: with a steady new raw level first sampled at edge 1, btn_state flips at edge DEBOUNCE_CYCLES+2.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Press pulse:
- btn_press[i] <= 1 on the same edge btn_state[i] goes 0->1; otherwise 0.
- Exactly one cycle wide per accepted press. No pulse on release.

Sticky latch, per channel, evaluated each edge:
- set = btn_press[i] next-state; clr = clr_en & clr_mask[i].
- set wins over clr, so a press arriving in the clear cycle is not lost.
- Otherwise clr drives the flag to 0; otherwise the flag holds.
- clr_mask bits are ignored when clr_en=0.

any_press:
- Registered OR of the next-state btn_latched.
- Rises on the same edge as the first latched bit and falls on the edge the last bit clears.

Simultaneous events:
- All channels operate independently; several channels may flip on the same edge.

Reset mid-operation:
- rst_n low at any point aborts every count in progress and clears all latches.
- A button held down through reset is re-accepted as a fresh press DEBOUNCE_CYCLES+2 edges after reset release, and generates btn_press.

Optional Feature:
Macro: BUTTON_DEBOUNCE_RELEASE_LATCH_EN
- Defined: adds output btn_rel_latched [NUM_BTN].
  - Set on the edge btn_state[i] goes 1->0.
  - Cleared by the same clr_en/clr_mask strobe, with set-wins priority.
  - Reset value 0.
  - any_press then ORs btn_latched and btn_rel_latched.
- Not defined: the port and its logic are absent; any_press covers btn_latched only.

Test Plan:
1. Clean press. DEBOUNCE_CYCLES=4, ACTIVE_LOW=1; drive btn_raw[0] 1->0 and hold 20 cycles.
   -> btn_state[0] rises at edge 6; btn_press[0] high for exactly 1 cycle at edge 6; btn_latched[0]=1 and any_press=1 from edge 6.
2. Bounce rejection. DEBOUNCE_CYCLES=4; pulse btn_raw[3] low for 3 cycles, high for 1, low for 3, then high.
   -> btn_state, btn_press and btn_latched stay 0x00 throughout.
3. Masked clear. Latch channels 0 and 7 (btn_latched=0x81); pulse clr_en=1 with clr_mask=0x01.
   -> btn_latched=0x80 next edge, any_press stays 1; a second clear with mask 0x80 gives btn_latched=0x00 and any_press=0.
4. Set-wins collision. Assert clr_en=1, clr_mask=0xFF on the exact edge btn_press[2] fires.
   -> btn_latched[2]=1 after the edge; other channels are cleared.
5. Reset mid-count. Hold btn_raw[5] low; assert rst_n=0 for 2 cycles after 2 debounce counts.
   -> all outputs 0 during reset; btn_state[5] rises exactly DEBOUNCE_CYCLES+2 edges after rst_n returns high, with one btn_press[5] pulse.
6. Release latch (macro defined). Press, then release btn_raw[1] with steady levels.
   -> btn_rel_latched[1]=1 on the edge btn_state[1] falls; without the macro the port is absent and the build passes.

Source files
------------

// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - button conditioner pin/flag bundle; BUTTON_DEBOUNCE_RELEASE_LATCH_EN adds btn_rel_latched
interface button_debounce_if #(
    parameter int NUM_BTN = 8
);
    logic [NUM_BTN-1:0] btn_raw;
    logic               clr_en;
    logic [NUM_BTN-1:0] clr_mask;
    logic [NUM_BTN-1:0] btn_state;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_latched;
    logic               any_press;
`ifdef BUTTON_DEBOUNCE_RELEASE_LATCH_EN
    logic [NUM_BTN-1:0] btn_rel_latched;

    modport master (
        output btn_raw, clr_en, clr_mask,
        input  btn_state, btn_press, btn_latched, any_press, btn_rel_latched
    );
    modport slave (
        input  btn_raw, clr_en, clr_mask,
        output btn_state, btn_press, btn_latched, any_press, btn_rel_latched
    );
`else
    modport master (
        output btn_raw, clr_en, clr_mask,
        input  btn_state, btn_press, btn_latched, any_press
    );
    modport slave (
        input  btn_raw, clr_en, clr_mask,
        output btn_state, btn_press, btn_latched, any_press
    );
`endif
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop sync, per-channel debounce, press pulse and sticky flags; BUTTON_DEBOUNCE_RELEASE_LATCH_EN adds release flags
module button_debounce #(
    parameter int NUM_BTN         = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    button_debounce_if.slave bus
);
    localparam logic [NUM_BTN-1:0]   REL_LVL = ACTIVE_LOW ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0]   s1_q, s1_d, s2_q, s2_d;
    logic [NUM_BTN-1:0]   state_q, state_d;
    logic [NUM_BTN-1:0]   press_q, press_d;
    logic [NUM_BTN-1:0]   latched_q, latched_d;
    logic                 any_q, any_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_BTN];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0]   pressed;
    logic [NUM_BTN-1:0]   clr;
`ifdef BUTTON_DEBOUNCE_RELEASE_LATCH_EN
    logic [NUM_BTN-1:0]   rel_q, rel_d;
`endif

    always_comb begin
        s1_d    = bus.btn_raw;
        s2_d    = s1_q;
        pressed = ACTIVE_LOW ? ~s2_q : s2_q;
        state_d = state_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any cycle agreeing with the accepted level restarts the hold count.
            if (pressed[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                state_d[i] = pressed[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
        press_d   = state_d & ~state_q;
        clr       = {NUM_BTN{bus.clr_en}} & bus.clr_mask;
        // Set beats clear so a press landing on the clear strobe survives.
        latched_d = press_d | (latched_q & ~clr);
`ifdef BUTTON_DEBOUNCE_RELEASE_LATCH_EN
        rel_d     = (state_q & ~state_d) | (rel_q & ~clr);
        any_d     = |(latched_d | rel_d);
`else
        any_d     = |latched_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= REL_LVL;
            s2_q      <= REL_LVL;
            state_q   <= '0;
            press_q   <= '0;
            latched_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
`ifdef BUTTON_DEBOUNCE_RELEASE_LATCH_EN
            rel_q     <= '0;
`endif
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            latched_q <= latched_d;
            any_q     <= any_d;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
`ifdef BUTTON_DEBOUNCE_RELEASE_LATCH_EN
            rel_q     <= rel_d;
`endif
        end
    end

    assign bus.btn_state   = state_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_latched = latched_q;
    assign bus.any_press   = any_q;
`ifdef BUTTON_DEBOUNCE_RELEASE_LATCH_EN
    assign bus.btn_rel_latched = rel_q;
`endif
endmodule
